// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu
// Load/store unit for the NPC core. It takes one load or store from execute,
// issues a single request to data memory, and hands the aligned/extended load
// data (or a store acknowledgement) back to write-back. Only one transaction
// is ever in flight.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request from execute (accepted only in IDLE)
//   req_wen, req_funct3        : 1 = store / RV32 size+sign encoding
//   req_addr, req_wdata        : byte address, LSB-aligned store data
//   mem_req_valid/mem_req_ready: request toward data memory
//   mem_wen, mem_addr          : write flag, word-aligned address
//   mem_wdata, mem_wmask       : lane-positioned store data, byte enables
//   mem_rsp_valid, mem_rdata   : memory read data / write done
//   rsp_valid/rsp_ready        : result toward write-back
//   rsp_rdata, rsp_err         : extended load data, misaligned/illegal flag
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised it stays high, and its payload stays
// unchanged, until that transfer happens.
module ysyx_23060332_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t      state_q,     state_d;
   logic        wen_q,       wen_d;
   logic [2:0]  f3_q,        f3_d;
   logic [1:0]  off_q,       off_d;
   logic        mem_wen_q,   mem_wen_d;
   logic [31:0] mem_addr_q,  mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wmask_q, mem_wmask_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q,   rsp_err_d;

   // Legality of the incoming request (only meaningful in IDLE).
   logic        f3_ok, misaligned, legal;
   logic [31:0] st_data;
   logic [3:0]  st_mask;
   logic [31:0] ld_shift, ld_data;

   always_comb begin
      if (req_wen) f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
      else         f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      legal      = f3_ok && !misaligned;
   end

   // Store data is replicated across lanes; the mask selects the live bytes.
   always_comb begin
      case (req_funct3[1:0])
         2'b00: begin
            st_data = {4{req_wdata[7:0]}};
            st_mask = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            st_data = {2{req_wdata[15:0]}};
            st_mask = 4'b0011 << req_addr[1:0];
         end
         default: begin
            st_data = req_wdata;
            st_mask = 4'hF;
         end
      endcase
   end

   // Load extraction from the raw memory word, using the latched byte offset.
   always_comb begin
      ld_shift = mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_data = {24'h0, ld_shift[7:0]};
         3'b101:  ld_data = {16'h0, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wen_d       = wen_q;
      f3_d        = f3_q;
      off_d       = off_q;
      mem_wen_d   = mem_wen_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wen_d       = req_wen;
               f3_d        = req_funct3;
               off_d       = req_addr[1:0];
               rsp_rdata_d = 32'h0;
               if (legal) begin
                  mem_wen_d   = req_wen;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_wdata_d = req_wen ? st_data : 32'h0;
                  mem_wmask_d = req_wen ? st_mask : 4'h0;
                  rsp_err_d   = 1'b0;
                  state_d     = S_REQ;
               end else begin
                  // Rejected access: memory side stays quiet, answer directly.
                  mem_wen_d   = 1'b0;
                  mem_addr_d  = 32'h0;
                  mem_wdata_d = 32'h0;
                  mem_wmask_d = 4'h0;
                  rsp_err_d   = 1'b1;
                  state_d     = S_RESP;
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               rsp_rdata_d = wen_q ? 32'h0 : ld_data;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wen_q       <= 1'b0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wmask_q <= 4'h0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign mem_req_valid = (state_q == S_REQ);
   assign rsp_valid     = (state_q == S_RESP);
   assign mem_wen       = mem_wen_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wmask     = {4'h0, mem_wmask_q};
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed and lightly randomised bench for ysyx_23060332_lsu. Expected
// responses are queued when a request is driven and popped when write-back
// takes the response; memory-side outputs are compared every cycle they are
// visible, which also covers their stability under backpressure.
module tb_ysyx_23060332_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_wen;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req_valid, mem_req_ready, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int errors = 0;
   int checks = 0;
   logic [32:0] exp_q[$];

   ysyx_23060332_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Independent reference for load extraction (lane select by offset).
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = off[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   // ---------------- driver + memory/write-back responder ----------------
   task automatic run_txn(input string tag, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int rdy_lat, input int rsp_lat,
                          input int wb_lat, input logic exp_err,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata,
                          input logic [7:0] exp_mask, input logic [31:0] exp_rdata,
                          input int exp_lat);
      int rdy_cnt = 0, wait_cnt = 0, wb_cnt = 0, nreq = 0, first_rsp = -1;
      logic hs_pend = 1'b0, in_wait = 1'b0, rsp_sent = 1'b0, done = 1'b0;
      logic [32:0] exp;
      chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
      req_valid     = 1'b1;
      req_wen       = wen;
      req_funct3    = f3;
      req_addr      = addr;
      req_wdata     = wdata;
      mem_rdata     = rdata;
      mem_rsp_valid = 1'b0;
      mem_req_ready = (rdy_lat == 0);
      rsp_ready     = (wb_lat == 0);
      exp_q.push_back({exp_err, exp_rdata});
      tick();
      // Scramble request inputs: they must be ignored while busy.
      req_valid  = 1'b0;
      req_wen    = ~wen;
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      for (int k = 0; k < 60 && !done; k++) begin
         if (hs_pend) begin
            in_wait = 1'b1;
            hs_pend = 1'b0;
         end
         chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
         if (mem_req_valid) begin
            chk({tag, "_mem_addr"},  mem_addr,          exp_maddr);
            chk({tag, "_mem_wdata"}, mem_wdata,         exp_mwdata);
            chk({tag, "_mem_wmask"}, 32'(mem_wmask),    32'(exp_mask));
            chk({tag, "_mem_wen"},   32'(mem_wen),      32'(wen));
            mem_req_ready = (rdy_cnt >= rdy_lat);
            rdy_cnt++;
            if (mem_req_ready) begin
               hs_pend = 1'b1;
               nreq++;
            end
         end else begin
            mem_req_ready = (rdy_lat == 0);
         end
         if (in_wait && !rsp_sent) begin
            mem_rsp_valid = (wait_cnt >= rsp_lat);
            wait_cnt++;
            if (mem_rsp_valid) rsp_sent = 1'b1;
         end else begin
            mem_rsp_valid = 1'b0;
         end
         if (rsp_valid) begin
            if (first_rsp < 0) first_rsp = k + 1;
            chk({tag, "_hold_rdata"}, rsp_rdata,     exp_q[0][31:0]);
            chk({tag, "_hold_err"},   32'(rsp_err),  32'(exp_q[0][32]));
            rsp_ready = (wb_cnt >= wb_lat);
            wb_cnt++;
            if (rsp_ready) begin
               exp = exp_q.pop_front();
               chk({tag, "_rsp_rdata"}, rsp_rdata,    exp[31:0]);
               chk({tag, "_rsp_err"},   32'(rsp_err), 32'(exp[32]));
               done = 1'b1;
            end
         end else begin
            rsp_ready = (wb_lat == 0);
         end
         tick();
      end
      chk({tag, "_completed"}, 32'(done), 32'd1);
      chk({tag, "_mem_requests"}, nreq, exp_err ? 0 : 1);
      if (exp_lat > 0) chk({tag, "_rsp_latency"}, first_rsp, exp_lat);
      chk({tag, "_back_idle"}, 32'(req_ready), 32'd1);
      chk({tag, "_rsp_dropped"}, 32'(rsp_valid), 32'd0);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      rsp_ready     = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic [31:0] r_addr, r_rd;

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
      rsp_ready = 1'b0;
      #2;
      chk("rst_req_ready", 32'(req_ready),     32'd1);
      chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mem_wen",   32'(mem_wen),       32'd0);
      chk("rst_mem_addr",  mem_addr,           32'h0);
      chk("rst_mem_wdata", mem_wdata,          32'h0);
      chk("rst_mem_wmask", 32'(mem_wmask),     32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid),     32'd0);
      chk("rst_rsp_err",   32'(rsp_err),       32'd0);
      chk("rst_rsp_rdata", rsp_rdata,          32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Zero-wait loads
      run_txn("lw",  1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0,
              1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_BEEF, 3);
      run_txn("lb",  1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 0,
              1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'hFFFF_FF80, 3);
      run_txn("lbu", 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 0,
              1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'h0000_0080, 3);
      run_txn("lhu", 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8011_2233, 0, 0, 0,
              1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'h0000_8011, 3);
      run_txn("lh",  1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8011_2233, 0, 0, 0,
              1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'hFFFF_8011, 3);

      // Stores: data lanes and masks; response data is always zero
      run_txn("sh",  1'b1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 0,
              1'b0, 32'h8000_0004, 32'hABCD_ABCD, 8'h0C, 32'h0, 3);
      run_txn("sb",  1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h1234_5678, 0, 0, 0,
              1'b0, 32'h8000_0000, 32'hA5A5_A5A5, 8'h02, 32'h0, 3);

      // Error paths: no memory traffic, response one cycle after accept
      run_txn("lw_mis", 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1111_1111, 0, 0, 0,
              1'b1, 32'h0, 32'h0, 8'h00, 32'h0, 1);
      run_txn("ld_f3_011", 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h1111_1111, 0, 0, 0,
              1'b1, 32'h0, 32'h0, 8'h00, 32'h0, 1);
      run_txn("sh_mis", 1'b1, 3'b001, 32'h8000_0003, 32'hFFFF_FFFF, 32'h0, 0, 0, 0,
              1'b1, 32'h0, 32'h0, 8'h00, 32'h0, 1);
      run_txn("st_f3_100", 1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 0,
              1'b1, 32'h0, 32'h0, 8'h00, 32'h0, 1);

      // Backpressure on every handshake
      run_txn("sw_bp", 1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 32'h5555_AAAA, 3, 2, 4,
              1'b0, 32'h8000_0020, 32'hCAFE_F00D, 8'h0F, 32'h0, -1);
      run_txn("lb_bp", 1'b0, 3'b000, 32'h8000_0021, 32'h0, 32'h0000_7F00, 3, 2, 4,
              1'b0, 32'h8000_0020, 32'h0, 8'h00, 32'h0000_007F, -1);

      // Randomised loads with random latencies
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 4))
            0:       r_f3 = 3'b010;
            1:       r_f3 = 3'b000;
            2:       r_f3 = 3'b001;
            3:       r_f3 = 3'b100;
            default: r_f3 = 3'b101;
         endcase
         r_off = 2'($urandom_range(0, 3));
         if (r_f3[1])      r_off    = 2'b00;
         else if (r_f3[0]) r_off[0] = 1'b0;
         r_addr = {30'($urandom), r_off};
         r_rd   = $urandom;
         run_txn("rnd_ld", 1'b0, r_f3, r_addr, 32'h0, r_rd, $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2), 1'b0,
                 {r_addr[31:2], 2'b00}, 32'h0, 8'h00, model_load(r_f3, r_off, r_rd), -1);
      end

      // Reset while waiting on memory, then a stray memory response
      req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h8000_0040; mem_req_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("rstw_req_issued", 32'(mem_req_valid), 32'd1);
      tick();
      mem_req_ready = 1'b0;
      chk("rstw_in_wait", 32'(mem_req_valid), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rstw_req_ready", 32'(req_ready),     32'd1);
      chk("rstw_mem_valid", 32'(mem_req_valid), 32'd0);
      chk("rstw_rsp_valid", 32'(rsp_valid),     32'd0);
      tick(); tick();
      rst_n = 1'b1;
      mem_rdata = 32'h1357_9BDF;
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stray_rsp_valid", 32'(rsp_valid),     32'd0);
         chk("stray_mem_valid", 32'(mem_req_valid), 32'd0);
         chk("stray_req_ready", 32'(req_ready),     32'd1);
         tick();
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
